// File: rtl/brush_painter.sv
// Paints a clipped square brush into a 4-bpp frame buffer, one pixel per cycle,
// and clears the whole canvas on request. Write port outputs are registered.
module brush_painter #(
    parameter int          H_RES    = 640,
    parameter int          V_RES    = 480,
    parameter int          ADDR_W   = 19,
    parameter logic [3:0]  BG_COLOR = 4'h0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [9:0]        cursor_loc_x,
    input  logic [8:0]        cursor_loc_y,
    input  logic [3:0]        cursor_color,
    input  logic [2:0]        stroke_width,
    input  logic              pen_down_in,
    input  logic              clear_in,
    output logic              we_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [3:0]        data_out,
    output logic              busy_out
);

    typedef enum logic [1:0] {IDLE, SETUP, PAINT, CLEAR} state_t;

    localparam logic signed [10:0] X_MAX     = 11'(H_RES - 1);
    localparam logic signed [10:0] Y_MAX     = 11'(V_RES - 1);
    localparam logic [10:0]        X_LIM     = 11'(H_RES);
    localparam logic [10:0]        Y_LIM     = 11'(V_RES);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    state_t state, next_state;

    // Captured stroke, last painted stroke, clamped bounds and pixel walker.
    logic [9:0] cap_x, last_x, x0_r, x1_r, px, nxt_px;
    logic [8:0] cap_y, last_y, y1_r, py, nxt_py;
    logic [3:0] cap_color, last_color;
    logic [2:0] cap_w, last_w;
    logic       last_valid;

    logic signed [10:0] lo_x, hi_x, hi_y;
    logic signed [9:0]  lo_y;
    logic [9:0]         x0, x1;
    logic [8:0]         y0, y1;
    logic               empty, trigger, last_px;
    logic [ADDR_W-1:0]  paint_addr, addr_d;
    logic               we_d;
    logic [3:0]         data_d;

    assign busy_out = (state != IDLE);

    assign trigger = pen_down_in &&
                     (!last_valid ||
                      {cursor_loc_x, cursor_loc_y, cursor_color, stroke_width} !=
                      {last_x, last_y, last_color, last_w});

    assign last_px = (px == x1_r) && (py == y1_r);

    // Clamp the brush square to the canvas with signed arithmetic.
    always_comb begin
        lo_x  = $signed({1'b0, cap_x}) - $signed({8'b0, cap_w});
        hi_x  = $signed({1'b0, cap_x}) + $signed({8'b0, cap_w});
        lo_y  = $signed({1'b0, cap_y}) - $signed({7'b0, cap_w});
        hi_y  = $signed({2'b0, cap_y}) + $signed({8'b0, cap_w});
        x0    = lo_x[10] ? 10'd0 : lo_x[9:0];
        x1    = (hi_x > X_MAX) ? X_MAX[9:0] : hi_x[9:0];
        y0    = lo_y[9] ? 9'd0 : lo_y[8:0];
        y1    = (hi_y > Y_MAX) ? Y_MAX[8:0] : hi_y[8:0];
        empty = ({1'b0, cap_x} >= X_LIM) || ({2'b0, cap_y} >= Y_LIM);
    end

    // Next raster position and its frame-buffer address.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        nxt_px = px;
        nxt_py = py;
        if (state == SETUP) begin
            nxt_px = x0;
            nxt_py = y0;
        end else if (px == x1_r) begin
            nxt_px = x0_r;
            nxt_py = py + 9'd1;
        end else begin
            nxt_px = px + 10'd1;
        end
        if (H_RES == 640)
            paint_addr = (ADDR_W'(nxt_py) << 9) + (ADDR_W'(nxt_py) << 7) + ADDR_W'(nxt_px);
        else
            paint_addr = ADDR_W'(nxt_py) * ADDR_W'(H_RES) + ADDR_W'(nxt_px);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clear_in) next_state = CLEAR;
                     else if (trigger) next_state = SETUP;
            SETUP:   if (clear_in) next_state = CLEAR;
                     else if (empty) next_state = IDLE;
                     else next_state = PAINT;
            PAINT:   if (clear_in) next_state = CLEAR;
                     else if (last_px) next_state = IDLE;
            CLEAR:   if (addr_out == LAST_ADDR) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Write port contents for the next cycle, keyed on where the FSM is going.
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_out;
        data_d = data_out;
        if (next_state == CLEAR) begin
            we_d   = 1'b1;
            data_d = BG_COLOR;
            addr_d = (state == CLEAR) ? addr_out + ADDR_W'(1) : '0;
        end else if (next_state == PAINT) begin
            we_d   = 1'b1;
            data_d = cap_color;
            addr_d = paint_addr;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            we_out     <= 1'b0;
            addr_out   <= '0;
            data_out   <= '0;
            last_valid <= 1'b0;
        end else begin
            we_out   <= we_d;
            addr_out <= addr_d;
            data_out <= data_d;
            if ((state == SETUP || state == PAINT) && next_state == IDLE)
                last_valid <= 1'b1;
            else if ((next_state == CLEAR && state != CLEAR) ||
                     (state == IDLE && !pen_down_in))
                last_valid <= 1'b0;
        end
    end

    // NOTE: pure datapath registers carry no reset; last_valid and the FSM
    // guarantee nothing reads them before they are loaded.
    always_ff @(posedge clk_in) begin
        if (state == IDLE && next_state == SETUP) begin
            cap_x     <= cursor_loc_x;
            cap_y     <= cursor_loc_y;
            cap_color <= cursor_color;
            cap_w     <= stroke_width;
        end
        if (state == SETUP) begin
            x0_r <= x0;
            x1_r <= x1;
            y1_r <= y1;
        end
        if (next_state == PAINT) begin
            px <= nxt_px;
            py <= nxt_py;
        end
        if ((state == SETUP || state == PAINT) && next_state == IDLE) begin
            last_x     <= cap_x;
            last_y     <= cap_y;
            last_color <= cap_color;
            last_w     <= cap_w;
        end
    end

endmodule
